// File: rtl/ram_2r1w_sync.sv
// rtl/ram_2r1w_sync.sv - two-read one-write register-file RAM with clear sequencer
module ram_2r1w_sync #(
  parameter int DEPTH = 16,
  parameter int INDEX = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  output logic             ready_o,
  input  logic [INDEX-1:0] addr0_i,
  input  logic             re0_i,
  output logic [WIDTH-1:0] data0_o,
  output logic             valid0_o,
  input  logic [INDEX-1:0] addr1_i,
  input  logic             re1_i,
  output logic [WIDTH-1:0] data1_o,
  output logic             valid1_o,
  input  logic [INDEX-1:0] addr0wr_i,
  input  logic [WIDTH-1:0] data0wr_i,
  input  logic             we0_i
);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  localparam logic [INDEX:0]   DEPTH_W = (INDEX+1)'(DEPTH);
  localparam logic [INDEX-1:0] LAST    = INDEX'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [INDEX-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data0_q, data0_d;
  logic [WIDTH-1:0] data1_q, data1_d;
  logic             valid0_q, valid0_d;
  logic             valid1_q, valid1_d;
  logic [WIDTH-1:0] ram_q [DEPTH];

  logic             wr_in_range;
  logic             rd0_in_range;
  logic             rd1_in_range;
  logic             is_ready;

  assign wr_in_range  = {1'b0, addr0wr_i} < DEPTH_W;
  assign rd0_in_range = {1'b0, addr0_i} < DEPTH_W;
  assign rd1_in_range = {1'b0, addr1_i} < DEPTH_W;
  assign is_ready     = (state_q == READY);

  // Clear sequencer: sweep entries 0..DEPTH-1, flush restarts from entry 0
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      if (flush_i) begin
        cnt_d = '0;
      end else if (cnt_q == LAST) begin
        state_d = READY;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + INDEX'(1);
      end
    end else if (flush_i) begin
      state_d = CLEAR;
      cnt_d   = '0;
    end
  end

  // Read ports: out-of-range reads give 0; a same-cycle write to the address wins
  always_comb begin
    data0_d  = data0_q;
    data1_d  = data1_q;
    valid0_d = 1'b0;
    valid1_d = 1'b0;
    if (is_ready && re0_i) begin
      valid0_d = 1'b1;
      if (!rd0_in_range)                        data0_d = '0;
      else if (we0_i && addr0wr_i == addr0_i)   data0_d = data0wr_i;
      else                                      data0_d = ram_q[addr0_i];
    end
    if (is_ready && re1_i) begin
      valid1_d = 1'b1;
      if (!rd1_in_range)                        data1_d = '0;
      else if (we0_i && addr0wr_i == addr1_i)   data1_d = data0wr_i;
      else                                      data1_d = ram_q[addr1_i];
    end
  end

  // Control and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= CLEAR;
      cnt_q    <= '0;
      data0_q  <= '0;
      data1_q  <= '0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
    end
  end

  // Storage array: not reset; zeroed by the sweep, written only when ready
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state_q == CLEAR) begin
        ram_q[cnt_q] <= '0;
      end else if (we0_i && wr_in_range) begin
        ram_q[addr0wr_i] <= data0wr_i;
      end
    end
  end

  assign ready_o  = is_ready;
  assign data0_o  = data0_q;
  assign data1_o  = data1_q;
  assign valid0_o = valid0_q;
  assign valid1_o = valid1_q;

endmodule
